uart_tx_buffer: RTL and testbench
=================================

// Module: uart_tx_buffer
// PURPOSE
//  Consumer of the memory-access stage's memory-mapped UART write (uart byte, uart_we strobe).
//  Queues each written byte in a FIFO and serialises it as 8N1 on a single TX line.
//  The pipeline never stalls on console output: a write to a full FIFO is dropped and flagged.
// PARAMETERS
//  CLK_FREQ    50_000_000  core clock frequency in Hz
//  BAUD_RATE   115_200     line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide, must be >= 2)
//  FIFO_DEPTH  16          byte entries; power of two, >= 2
// PORTS
//  clk           in   1  core clock, all logic on rising edge
//  rst           in   1  synchronous reset, active-high
//  uart          in   8  byte written by the store unit
//  uart_we       in   1  1-cycle write strobe for uart
//  tx            out  1  serial line, idle high
//  tx_busy       out  1  1 while a frame is on the line or the FIFO is non-empty
//  fifo_full     out  1  FIFO holds FIFO_DEPTH entries
//  overflow      out  1  sticky: set when a write was dropped, cleared only by rst
//  fifo_count    out  $clog2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (rst=1 at a rising edge): tx=1, tx_busy=0, fifo_full=0, overflow=0, fifo_count=0,
//   FSM=IDLE, pointers/counters=0. Takes priority over everything, including mid-frame:
//   tx returns high on the same edge, the partial frame and FIFO contents are discarded.
//  Push: uart_we=1 at a rising edge writes uart into FIFO. Each high cycle = one push.
//   Full and no pop in same cycle -> byte dropped, overflow<=1, count unchanged.
//   Full with pop in same cycle -> push accepted (count stays FIFO_DEPTH).
//   Simultaneous push+pop on non-full FIFO -> count unchanged, both take effect.
//  Pointers: $clog2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ, low bits equal.
//  FSM (tx_state_e): IDLE, START, DATA, STOP.
//   IDLE: tx=1. If FIFO non-empty: pop head into shift reg, bit_cnt<=0, baud_cnt<=0 -> START.
//    A byte pushed at edge N is popped no earlier than edge N+1 (no write-through).
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shift right;
//    after bit_cnt==7 completes -> STOP.
//   STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE. Next byte's START begins the cycle after
//    IDLE is entered (1-cycle inter-frame gap at idle high).
//  tx is driven from a register (glitch-free); frame = 10*CLKS_PER_BIT (+1 IDLE) cycles.
//  baud_cnt width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, terminal count advances bit.
//  tx_busy = (FSM != IDLE) || (fifo_count != 0), registered-equivalent, no combinational path
//   from uart_we.
//  X on uart while uart_we=0 has no effect.
// STRUCTURE
//  Package UartTypes: tx_state_e enum {IDLE,START,DATA,STOP}, UART_DATA_WIDTH=8,
//   UART_FRAME_BITS=10. UART MMIO address constant stays in the existing shared defines.
//  Sub-module sync_fifo #(WIDTH, DEPTH): push/pop/full/empty/count, registered read data
//   held at head (show-ahead). Top holds baud counter, bit counter, shift reg, FSM.
// TESTING  (bench uses CLK_FREQ=10, BAUD_RATE=1 -> CLKS_PER_BIT=10, FIFO_DEPTH=4)
//  Single byte: push 0x41 -> tx low 10 cycles, then 1,0,0,0,0,0,1,0 each 10 cycles,
//   high 10 cycles; tx_busy falls after stop; decoded byte == 0x41.
//  Back-to-back: push 0x55,0xAA,0x00 on 3 consecutive cycles -> three frames in order,
//   1-cycle idle gap between each, fifo_count peaks at 3 (or 2 if first popped).
//  Overflow: push 6 bytes 0x01..0x06 consecutively -> 0x01..0x05 transmitted (one popped
//   to shifter), 0x06 dropped, overflow=1 and stays 1 after line goes idle.
//  Full + pop same cycle: fill to 4 while IDLE about to pop, push on pop edge -> accepted,
//   overflow stays 0, count stays 4.
//  Reset mid-frame: push 0xF0, assert rst during DATA bit 3 -> tx=1 next edge, all outputs
//   at reset values, no further frame; push 0x0F after -> clean frame of 0x0F.
//  Random: 1000 random bytes with random gaps, scoreboard vs. line decoder; zero mismatches,
//   overflow count in model matches dropped bytes.

Source files
------------

// File: rtl/UartTypes.sv
// -----------------------------------------------------------------------------
// UartTypes
// Shared types and constants for the console UART transmit path.
//   tx_state_e      : transmitter FSM state (IDLE, START, DATA, STOP)
//   UART_DATA_WIDTH : payload bits per character
//   UART_FRAME_BITS : start + data + stop bits on the line per character
// The UART MMIO address lives with the other shared address defines, not here.
// -----------------------------------------------------------------------------
package UartTypes;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is always presented on pop_data
// straight from the storage registers, so a pop consumes the value that was
// visible during that cycle.
// Ports:
//   clk        in   core clock, rising edge
//   rst        in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data this cycle
//   push_data  in   WIDTH-bit write data
//   pop        in   discard the head entry this cycle
//   pop_data   out  head entry (valid while empty is 0)
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   count      out  occupancy, $clog2(DEPTH)+1 bits
// A push into a full FIFO is accepted only when a pop happens in the same cycle;
// a pop on an empty FIFO is ignored. DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
    // that differ only in the wrap bit mean full.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // When full, the slot being written is the head slot being popped, which is
    // safe because the head is read before the edge that overwrites it.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer
// Console output path for the memory stage: every byte stored to the UART
// register is queued and sent as 8N1 on tx. The pipeline never waits on the
// console; a store that finds the queue full is dropped and remembered in the
// sticky overflow flag.
// Ports:
//   clk         in   core clock, rising edge
//   rst         in   synchronous active-high reset, aborts any frame in flight
//   uart        in   byte from the store unit
//   uart_we     in   one-cycle write strobe for uart
//   tx          out  serial line, idle high, driven from a flop
//   tx_busy     out  a frame is on the line or bytes are waiting
//   fifo_full   out  queue holds FIFO_DEPTH bytes
//   overflow    out  sticky, a byte was dropped since the last reset
//   fifo_count  out  queue occupancy
// CLKS_PER_BIT = CLK_FREQ / BAUD_RATE must be at least 2.
// -----------------------------------------------------------------------------
module uart_tx_buffer
    import UartTypes::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    uart,
    input  logic                          uart_we,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(UART_DATA_WIDTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_WIDTH - 1);

    tx_state_e                  state_q, state_d;
    logic [BAUD_W-1:0]          baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic                       overflow_q, overflow_d;

    logic                       fifo_pop;
    logic                       fifo_empty;
    logic [UART_DATA_WIDTH-1:0] fifo_head;
    logic                       baud_done;

    sync_fifo #(
        .WIDTH (UART_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (uart_we),
        .push_data (uart),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign baud_done = (baud_cnt_q == BAUD_LAST);

    // Transmit sequencer. tx_d is the line level for the state being entered,
    // so the tx flop changes on the same edge as the state and never glitches.
    // Within DATA the shifter moves only between bits, so shift_q[0] is the bit
    // currently on the line and shift_q[1] is the next one.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // The FIFO only reports non-empty the cycle after a push, so a
                // byte is never popped on the edge that writes it.
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_head;
                    bit_cnt_d  = '0;
                    baud_cnt_d = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    state_d    = DATA;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    tx_d       = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // A write is lost only when the queue is full and the transmitter is not
    // freeing a slot on the same edge.
    always_comb begin
        overflow_d = overflow_q | (uart_we && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    // Built only from flops, so there is no path from uart_we to tx_busy.
    assign tx_busy  = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffer
// Drives uart_tx_buffer with CLKS_PER_BIT = 10 and a 4-deep queue. A queue
// based reference model predicts every output each cycle from the line timing
// (a frame is 100 cycles of start/data/stop, the next byte can leave one cycle
// after that), and a line decoder turns tx back into bytes for a scoreboard.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffer;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] uart = 8'h00;
    logic       uart_we = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       overflow;
    logic [2:0] fifo_count;

    uart_tx_buffer #(
        .CLK_FREQ   (10),
        .BAUD_RATE  (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart       (uart),
        .uart_we    (uart_we),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    int         m_next_free = 0;
    int         m_pop_edge  = 0;
    logic [7:0] m_byte      = 8'h00;
    bit         m_active    = 1'b0;
    bit         m_ovf       = 1'b0;
    int         m_drops     = 0;
    int         resets      = 0;
    bit         chk_en      = 1'b0;

    // Line decoder state
    bit         dec_active = 1'b0;
    int         dec_off    = 0;
    int         dec_resets = 0;
    logic [7:0] dec_byte   = 8'h00;
    logic [7:0] last_rx    = 8'h00;
    int         rx_count   = 0;
    int         peak       = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line level implied by the byte currently being sent and its age.
    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = (cyc - m_pop_edge) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    // Model update at each rising edge: pop first, then the push sees the
    // freed slot.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_active    = 1'b0;
            m_ovf       = 1'b0;
            m_next_free = cyc + 1;
            resets++;
        end else begin
            if (m_active && (cyc - m_pop_edge) >= FRAME) m_active = 1'b0;
            if (cyc >= m_next_free && m_q.size() > 0) begin
                m_byte      = m_q.pop_front();
                m_pop_edge  = cyc;
                m_active    = 1'b1;
                m_next_free = cyc + FRAME + 1;
            end
            if (uart_we) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(uart);
                    exp_q.push_back(uart);
                end else begin
                    m_ovf = 1'b1;
                    m_drops++;
                end
            end
        end
    end

    // Per-cycle output comparison and line decoding on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("tx", tx, exp_tx());
            checkOutput("tx_busy", tx_busy, m_active || (m_q.size() > 0));
            checkOutput("fifo_count", fifo_count, m_q.size());
            checkOutput("fifo_full", fifo_full, m_q.size() == DEPTH);
            checkOutput("overflow", overflow, m_ovf);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);

            if (resets != dec_resets) begin
                dec_active = 1'b0;
                dec_resets = resets;
            end
            if (!dec_active) begin
                if (tx == 1'b0) begin
                    dec_active = 1'b1;
                    dec_off    = 0;
                end
            end else begin
                dec_off++;
                if (dec_off == 5) begin
                    checkOutput("rx_start", tx, 1'b0);
                end else if (dec_off >= 15 && dec_off <= 85 && (dec_off - 15) % 10 == 0) begin
                    dec_byte[(dec_off - 15) / 10] = tx;
                end else if (dec_off == 95) begin
                    checkOutput("rx_stop", tx, 1'b1);
                    last_rx = dec_byte;
                    rx_count++;
                    dec_active = 1'b0;
                    if (exp_q.size() == 0) checkOutput("rx_unexpected", 1, 0);
                    else checkOutput("rx_byte", dec_byte, exp_q.pop_front());
                end
            end
        end
    end

    // One-cycle write strobe; caller is at a falling edge and returns at the next.
    task automatic applyStimulus(input logic [7:0] b);
        uart    = b;
        uart_we = 1'b1;
        @(negedge clk);
        uart_we = 1'b0;
        uart    = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDrain(input int budget);
        int i = 0;
        while ((tx_busy || m_active || m_q.size() > 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) checkOutput("drain_timeout", 0, 1);
        idle(2);
    endtask

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rx0;
        int d0;
        int i;
        int p;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_tx", tx, 1'b1);
        checkOutput("rst_busy", tx_busy, 1'b0);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_full", fifo_full, 1'b0);
        checkOutput("rst_ovf", overflow, 1'b0);
        chk_en = 1'b1;
        idle(3);

        // Single byte
        rx0 = rx_count;
        applyStimulus(8'h41);
        waitDrain(400);
        checkOutput("single_busy", tx_busy, 1'b0);
        checkOutput("single_rx", rx_count - rx0, 1);
        checkOutput("single_byte", last_rx, 8'h41);

        // Back-to-back writes
        rx0  = rx_count;
        peak = 0;
        applyStimulus(8'h55);
        applyStimulus(8'hAA);
        applyStimulus(8'h00);
        waitDrain(800);
        checkOutput("b2b_peak", peak, 2);
        checkOutput("b2b_rx", rx_count - rx0, 3);
        checkOutput("b2b_last", last_rx, 8'h00);

        // Full queue with a pop on the same edge as the push
        rx0 = rx_count;
        applyStimulus(8'hC0);
        for (int k = 1; k <= 4; k++) applyStimulus(8'(8'hC0 + k));
        checkOutput("fullpop_prefull", fifo_full, 1'b1);
        i = 0;
        while (cyc + 1 != m_next_free && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (i >= 300) checkOutput("fullpop_timeout", 0, 1);
        applyStimulus(8'hC5);
        checkOutput("fullpop_count", fifo_count, 4);
        checkOutput("fullpop_ovf", overflow, 1'b0);
        waitDrain(1000);
        checkOutput("fullpop_rx", rx_count - rx0, 6);
        checkOutput("fullpop_last", last_rx, 8'hC5);

        // Overflow
        rx0 = rx_count;
        for (int k = 1; k <= 6; k++) applyStimulus(8'(k));
        checkOutput("ovf_flag", overflow, 1'b1);
        waitDrain(1000);
        checkOutput("ovf_sticky", overflow, 1'b1);
        checkOutput("ovf_rx", rx_count - rx0, 5);
        checkOutput("ovf_last", last_rx, 8'h05);

        // Reset in the middle of data bit 3
        rx0 = rx_count;
        applyStimulus(8'hF0);
        i = 0;
        while (!m_active && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (i >= 20) checkOutput("rstmid_timeout", 0, 1);
        p = m_pop_edge;
        while (cyc < p + 43) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstmid_tx", tx, 1'b1);
        checkOutput("rstmid_busy", tx_busy, 1'b0);
        checkOutput("rstmid_count", fifo_count, 0);
        checkOutput("rstmid_full", fifo_full, 1'b0);
        checkOutput("rstmid_ovf", overflow, 1'b0);
        idle(150);
        checkOutput("rstmid_noframe", rx_count - rx0, 0);
        applyStimulus(8'h0F);
        waitDrain(400);
        checkOutput("rstmid_rx", rx_count - rx0, 1);
        checkOutput("rstmid_byte", last_rx, 8'h0F);

        // Random traffic
        rx0 = rx_count;
        d0  = m_drops;
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(8'($urandom));
            if ($urandom_range(0, 9) == 0) idle($urandom_range(100, 400));
            else idle($urandom_range(0, 20));
        end
        waitDrain(2000);
        checkOutput("rand_account", (rx_count - rx0) + (m_drops - d0), 1000);
        checkOutput("rx_pending", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
